// File: rtl/operacion.sv
// operacion: 4-bit unsigned restoring divider producing one quotient bit every SCAN_DIV clocks
// ports: clk, rst (async, active-high), dividendo/divisor (operands, captured after reset), cociente/resto (registered result)
module operacion #(
    parameter int SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dividendo,
    input  logic [3:0] divisor,
    output logic [3:0] cociente,
    output logic [3:0] resto
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t          r_state, w_next;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_bit;
    logic [3:0]      r_a, r_b, r_rem, r_q, r_cociente, r_resto, w_q, w_rem;
    logic [4:0]      w_p;
    logic            w_step, w_ge, w_last;
    assign w_step   = r_state == RUN && r_cnt == CW'(SCAN_DIV - 1);
    assign w_p      = {r_rem, r_a[r_bit]};
    assign w_ge     = w_p >= {1'b0, r_b};
    // the difference always fits in 4 bits because the stored remainder stays below B
    assign w_rem    = w_ge ? 4'(w_p - {1'b0, r_b}) : w_p[3:0];
    assign w_last   = w_step && r_bit == 2'd0;
    assign cociente = r_cociente;
    assign resto    = r_resto;
    always_comb begin
        w_q        = r_q;
        w_q[r_bit] = w_ge;
    end
    always_comb w_next = r_state == IDLE ? RUN : w_last ? DONE : r_state;
    always_ff @(posedge clk or posedge rst)
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_bit      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_cociente <= '0;
            r_resto    <= '0;
        end else if (r_state == IDLE) begin
            r_a   <= dividendo;
            r_b   <= divisor;
            r_rem <= '0;
            r_q   <= '0;
            r_cnt <= '0;
            r_bit <= 2'd3;
        end else if (r_state == RUN) begin
            r_cnt <= w_step ? '0 : r_cnt + 1'b1;
            if (w_step) begin
                r_rem <= w_rem;
                r_q   <= w_q;
                r_bit <= r_bit - 2'd1;
            end
            // results appear on the same edge that enters DONE
            if (w_last) begin
                r_cociente <= w_q;
                r_resto    <= w_rem;
            end
        end
    end
endmodule

// File: tb/tb_operacion.sv
// tb_operacion: scoreboard bench for operacion with SCAN_DIV=4 and SCAN_DIV=1 instances
module tb_operacion;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dividendo = '0, divisor = '0;
    logic [3:0] q4, r4, q1, r1;
    int         total = 0, bad = 0;
    typedef struct {
        bit         sel;
        logic [3:0] q;
        logic [3:0] r;
        string      nm;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    operacion #(.SCAN_DIV(4)) u_d4 (.clk(clk), .rst(rst), .dividendo(dividendo), .divisor(divisor), .cociente(q4), .resto(r4));
    operacion #(.SCAN_DIV(1)) u_d1 (.clk(clk), .rst(rst), .dividendo(dividendo), .divisor(divisor), .cociente(q1), .resto(r1));

    task automatic expect_out(input bit sel, input logic [3:0] q, input logic [3:0] r, input string nm);
        exp_t e;
        e.sel = sel;
        e.q   = q;
        e.r   = r;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    initial forever begin
        exp_t       e;
        logic [3:0] aq, ar;
        wait (sb.size() != 0);
        e  = sb.pop_front();
        aq = e.sel ? q1 : q4;
        ar = e.sel ? r1 : r4;
        total++;
        if (aq !== e.q || ar !== e.r) begin
            bad++;
            $display("FAIL %s (SCAN_DIV=%0d): got q=%0d r=%0d want q=%0d r=%0d",
                     e.nm, e.sel ? 1 : 4, aq, ar, e.q, e.r);
        end
    end

    task automatic start(input logic [3:0] a, input logic [3:0] b);
        rst       = 1'b1;
        dividendo = a;
        divisor   = b;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq, input logic [3:0] er, input string nm);
        start(a, b);
        repeat (5) @(posedge clk);
        #1 expect_out(1'b1, eq, er, nm);
        repeat (12) @(posedge clk);
        #1 expect_out(1'b0, eq, er, nm);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 expect_out(1'b0, 4'd0, 4'd0, "reset");
        expect_out(1'b1, 4'd0, 4'd0, "reset");
        run(4'd9,  4'd3, 4'd3,  4'd0, "9/3");
        run(4'd7,  4'd2, 4'd3,  4'd1, "7/2");
        run(4'd15, 4'd4, 4'd3,  4'd3, "15/4");
        run(4'd8,  4'd5, 4'd1,  4'd3, "8/5");
        run(4'd15, 4'd1, 4'd15, 4'd0, "15/1");
        run(4'd3,  4'd7, 4'd0,  4'd3, "3/7");
        run(4'd0,  4'd5, 4'd0,  4'd0, "0/5");
        run(4'd6,  4'd0, 4'd15, 4'd6, "6/0");
        // latency: SCAN_DIV=1 valid at edge 5, SCAN_DIV=4 at edge 17, then held
        start(4'd9, 4'd3);
        repeat (4) @(posedge clk);
        #1 expect_out(1'b1, 4'd0, 4'd0, "lat edge4");
        @(posedge clk);
        #1 expect_out(1'b1, 4'd3, 4'd0, "lat edge5");
        repeat (11) @(posedge clk);
        #1 expect_out(1'b0, 4'd0, 4'd0, "lat edge16");
        @(posedge clk);
        #1 expect_out(1'b0, 4'd3, 4'd0, "lat edge17");
        dividendo = 4'd1;
        divisor   = 4'd1;
        repeat (20) @(posedge clk);
        #1 expect_out(1'b0, 4'd3, 4'd0, "hold");
        expect_out(1'b1, 4'd3, 4'd0, "hold");
        // asynchronous reset in the middle of a SCAN_DIV=4 division
        start(4'd9, 4'd3);
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1 expect_out(1'b0, 4'd0, 4'd0, "async rst");
        expect_out(1'b1, 4'd0, 4'd0, "async rst");
        run(4'd14, 4'd3, 4'd4, 4'd2, "14/3 after rst");
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
                logic [3:0] eq, er;
                eq = b == 0 ? 4'hF : 4'(a / b);
                er = b == 0 ? 4'(a) : 4'(a % b);
                run(4'(a), 4'(b), eq, er, $sformatf("exh %0d/%0d", a, b));
            end
        #1;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/operacion.md
Name: operacion

Overview:
- 4-bit unsigned sequential divider using the restoring shift/subtract algorithm. It produces one quotient bit per step; the step rate is set by SCAN_DIV.
- Operands are captured once after reset is released, and the result is held until the next reset.
- Intended as the arithmetic core behind the board-level input/display logic. The slow step rate allows the division to be observed on hardware.

Parameters:
- SCAN_DIV, default 4 (integer, must be ≥1): number of clk cycles per division step (one quotient bit per step).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- dividendo  input  4  unsigned dividend A; must be stable from reset release until the result is valid.
- divisor  input  4  unsigned divisor B; same stability rule as dividendo.
- cociente  output  4  unsigned quotient Q, registered.
- resto  output  4  unsigned remainder R, registered.

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE; step counter=0; bit counter=0; internal remainder, quotient and operand registers=0.
  - cociente=0, resto=0.
  - Reset asserted mid-division aborts immediately and clears everything.
- States: IDLE → RUN → DONE.
- IDLE:
  - Entered on reset.
  - First rising edge with rst=0: capture dividendo into A_reg and divisor into B_reg; clear the partial remainder (5 bits) and quotient; clear the step counter; bit index=3; go to RUN.
- RUN:
  - Step counter counts 0..SCAN_DIV-1.
  - When it equals SCAN_DIV-1, execute one restoring step and wrap the counter to 0:
    - P = {partial_rem[3:0], A_reg[bit]} (5 bits);
    - if P ≥ {1'b0, B_reg}: partial_rem = P - B_reg and Q[bit]=1;
    - else: partial_rem = P and Q[bit]=0.
  - After the step with bit index 0, go to DONE. Otherwise decrement the bit index.
- DONE:
  - On entry, load cociente=Q and resto=partial_rem[3:0].
  - Hold all outputs indefinitely; input changes are ignored until the next reset.
- Latency: the result is valid exactly 1 + 4*SCAN_DIV rising edges after the first edge with rst=0. That is 17 edges for SCAN_DIV=4, and always ≤ 4*SCAN_DIV+2.
- During IDLE/RUN, cociente and resto stay at 0; there are no partial results on the outputs.
- Arithmetic:
  - All unsigned.
  - Result satisfies A = Q*B + R and R < B for B≠0.
  - Partial remainder is 5 bits wide internally, so the compare never overflows.
- Divide by zero (B=0): the algorithm runs unchanged; the required result is cociente=4'hF, resto=dividendo. No error flag.
- A < B: cociente=0, resto=A.
- A=0: cociente=0, resto=0 (for B≠0).
- SCAN_DIV=1: one step per cycle; latency 5 edges.

Test Plan:
- SCAN_DIV=4:
  - Hold rst=1, apply A=9, B=3, deassert rst, wait 18 edges → cociente=3, resto=0.
  - Repeat with A=7, B=2 → 3/1; A=15, B=4 → 3/3; A=8, B=5 → 1/3.
- Latency check, A=9, B=3:
  - Outputs are 0 at edge 16 after release.
  - Outputs are 3/0 at edge 17.
  - Outputs hold 3/0 for 20 more edges while the inputs change to A=1, B=1.
- Boundaries:
  - A=15, B=1 → 15/0; A=3, B=7 → 0/3; A=0, B=5 → 0/0.
  - A=6, B=0 → cociente=15, resto=6.
- Reset mid-operation:
  - Assert rst asynchronously (between clock edges) 6 edges into RUN → outputs are 0 immediately, before the next edge.
  - Release with A=14, B=3 → 4/2 after 17 edges.
- Exhaustive: all 256 A/B combinations with SCAN_DIV=1 and SCAN_DIV=4.
  - Compare against A/B and A%B for B≠0; for B=0, expect F/A.
